// File: rtl/count_snapshot_fifo.sv
// Snapshot FIFO: captures a live counter value on a strobe and buffers it
// for a valid/ready consumer, with sticky overflow and saturating drop count.
module count_snapshot_fifo #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       capture,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt,
  input  logic                       clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_ovf;
  logic [DROP_W-1:0] r_drop_cnt;

  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid && out_ready;
  assign w_push  = capture && (!w_full || w_pop);
  assign w_drop  = capture && w_full && !w_pop;

  // Empty reads as zero so the port is clean after reset.
  assign out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign out_valid = w_valid;
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign drop_cnt  = r_drop_cnt;

  // Storage write; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && w_push)
      r_mem[r_wr_ptr] <= count_in;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Overflow flag and saturating drop count; a drop beats a clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (clear_ovf)
        r_drop_cnt <= DROP_W'(1);
      else if (!(&r_drop_cnt))
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end else if (clear_ovf) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

endmodule
